// File: rtl/prog_load_pkg.sv
// Shared types and constants for the program loader / run sequencer.
package prog_load_pkg;

  localparam int unsigned DEPTH_DEF      = 24;
  localparam logic [15:0] WDOG_LIMIT_DEF = 16'd4000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_READY = 3'd3,
    ST_CLR   = 3'd4,
    ST_RUN   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/prog_load_sched_frame_rx.sv
// Byte deframer datapath: length check, payload write strobes, XOR checksum.
// The phase (IDLE/LOAD/CSUM) is owned by the top FSM and passed in.
module frame_rx
  import prog_load_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  state_e            state_i,
  input  logic              byte_acc_i,
  input  logic [DATA_W-1:0] byte_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              len_ok_o,
  output logic              len_err_o,
  output logic              pay_last_o,
  output logic              csum_ok_o,
  output logic              csum_err_o
);

  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              len_legal_s;
  logic              in_idle_s, in_load_s, in_csum_s;

  assign in_idle_s   = (state_i == ST_IDLE);
  assign in_load_s   = (state_i == ST_LOAD);
  assign in_csum_s   = (state_i == ST_CSUM);
  assign len_legal_s = (byte_i != {DATA_W{1'b0}}) && (byte_i <= DATA_W'(DEPTH));

  // Decode per-byte events; payload bytes are written in the cycle they are accepted.
  always_comb begin
    len_ok_o    = in_idle_s & byte_acc_i & len_legal_s;
    len_err_o   = in_idle_s & byte_acc_i & ~len_legal_s;
    mem_we_o    = in_load_s & byte_acc_i;
    pay_last_o  = in_load_s & byte_acc_i & ((idx_q + ADDR_W'(1)) == len_q);
    csum_ok_o   = in_csum_s & byte_acc_i & (byte_i == xor_q);
    csum_err_o  = in_csum_s & byte_acc_i & (byte_i != xor_q);
    mem_addr_o  = idx_q;
    mem_wdata_o = byte_i;
  end

  // Next-state for length, write index and running XOR.
  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    xor_d = xor_q;
    if (len_ok_o) begin
      len_d = byte_i[ADDR_W-1:0];  // legal lengths fit in ADDR_W bits
      idx_d = {ADDR_W{1'b0}};
      xor_d = {DATA_W{1'b0}};
    end else if (mem_we_o) begin
      idx_d = idx_q + ADDR_W'(1);
      xor_d = xor_q ^ byte_i;
    end else begin
      idx_d = idx_q;
    end
  end

  // Deframer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= {ADDR_W{1'b0}};
      idx_q <= {ADDR_W{1'b0}};
      xor_q <= {DATA_W{1'b0}};
    end else begin
      len_q <= len_d;
      idx_q <= idx_d;
      xor_q <= xor_d;
    end
  end

endmodule

// File: rtl/prog_load_sched.sv
// Program loader, run sequencer and instruction-memory port arbiter for the
// accumulator core. The loader owns the port outside RUN; the core owns it in RUN.
module prog_load_sched
  import prog_load_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              start,
  input  logic              abort,
  input  logic              core_fetch_req,
  input  logic [ADDR_W-1:0] core_fetch_addr,
  output logic              core_fetch_gnt,
  input  logic              core_halted,
  output logic              core_clr,
  output logic              core_run_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [2:0]        state_o,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done
);

  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byte_acc_s;
  logic              rx_we_s, len_ok_s, len_err_s, pay_last_s, csum_ok_s, csum_err_s;
  logic [ADDR_W-1:0] rx_addr_s;
  logic [DATA_W-1:0] rx_wdata_s;

  // abort drops any byte offered in the same cycle
  assign byte_acc_s = in_valid & in_ready & ~abort;

  frame_rx #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_frame_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_q),
    .byte_acc_i  (byte_acc_s),
    .byte_i      (in_data),
    .mem_we_o    (rx_we_s),
    .mem_addr_o  (rx_addr_s),
    .mem_wdata_o (rx_wdata_s),
    .len_ok_o    (len_ok_s),
    .len_err_o   (len_err_s),
    .pay_last_o  (pay_last_s),
    .csum_ok_o   (csum_ok_s),
    .csum_err_o  (csum_err_s)
  );

  // Next state, error code and run-cycle counter.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (len_err_s) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else if (len_ok_s) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (pay_last_s) state_d = ST_CSUM;
          else            state_d = ST_LOAD;
        end
        ST_CSUM: begin
          if (csum_ok_s) begin
            state_d = ST_READY;
          end else if (csum_err_s) begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end else begin
            state_d = ST_CSUM;
          end
        end
        ST_READY: begin
          if (start) state_d = ST_CLR;
          else       state_d = ST_READY;
        end
        ST_CLR: begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          else                        cnt_d = cnt_q;
          // a halt seen on the watchdog's last cycle still counts as a clean finish
          if (core_halted) begin
            state_d = ST_DONE;
          end else if (cnt_q == (WDOG_LIMIT - CNT_W'(1))) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start) state_d = ST_CLR;
          else       state_d = ST_DONE;
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
        end
      endcase
    end
  end

  // State, error and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode and memory-port mux: core owns the port only in RUN.
  always_comb begin
    in_ready       = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
    core_clr       = (state_q == ST_CLR);
    core_run_en    = (state_q == ST_RUN);
    done           = (state_q == ST_DONE);
    core_fetch_gnt = 1'b0;
    mem_re         = 1'b0;
    mem_we         = rx_we_s;
    mem_addr       = rx_addr_s;
    mem_wdata      = rx_wdata_s;
    if (state_q == ST_RUN) begin
      core_fetch_gnt = core_fetch_req;
      mem_re         = core_fetch_req;
      mem_addr       = core_fetch_addr;
    end else begin
      core_fetch_gnt = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign err_code    = err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_load_sched.sv
// Self-checking bench for prog_load_sched: scoreboard of expected memory writes
// plus directed checks of the run sequencer, errors and abort.
module tb_prog_load_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, start, abort;
  logic [7:0]  in_data;
  logic        core_fetch_req, core_fetch_gnt, core_halted, core_clr, core_run_en;
  logic [4:0]  core_fetch_addr, mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re, done;
  logic [2:0]  state_o;
  logic [1:0]  err_code;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] exp_q[$];

  // toy core: halts in its 7th RUN cycle when halt_en is set
  bit       halt_en = 1'b1;
  int       k_q = 0;
  int       run_cnt = 0;
  int       clr_cnt = 0;
  int       base_run, base_clr;

  prog_load_sched #(.WDOG_LIMIT(16'd10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .abort(abort), .core_fetch_req(core_fetch_req),
    .core_fetch_addr(core_fetch_addr), .core_fetch_gnt(core_fetch_gnt),
    .core_halted(core_halted), .core_clr(core_clr), .core_run_en(core_run_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .state_o(state_o), .err_code(err_code), .cycle_count(cycle_count), .done(done)
  );

  always #5 clk = ~clk;

  assign core_halted = halt_en && (k_q >= 6);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // toy core step counter
  always @(posedge clk) begin
    if (core_clr) k_q <= 0;
    else if (core_run_en) k_q <= k_q + 1;
  end

  // count RUN cycles and clear pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n && core_run_en) run_cnt <= run_cnt + 1;
    if (rst_n && core_clr) clr_cnt <= clr_cnt + 1;
  end

  // scoreboard: every write must match the next expected (addr,data)
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected", {31'd0, mem_we}, 32'd0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check_val("wr_addr", {27'd0, mem_addr}, {27'd0, e[12:8]});
        check_val("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
    if (rst_n && core_fetch_req && (state_o != 3'd5)) begin
      check_val("gnt_outside_run", {30'd0, core_fetch_gnt, mem_re}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit wr, input logic [4:0] a);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    if (wr) exp_q.push_back({a, b});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound);
    int i;
    i = 0;
    @(negedge clk);
    while ((state_o != s) && (i < bound)) begin
      @(negedge clk);
      i++;
    end
    check_val("reach_state", {29'd0, state_o}, {29'd0, s});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0; abort = 1'b0;
    core_fetch_req = 1'b0; core_fetch_addr = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_state", {29'd0, state_o}, 32'd0);
    check_val("rst_flags", {25'd0, in_ready, mem_we, mem_re, core_clr, core_run_en, done, core_fetch_gnt}, 32'h40);
    check_val("rst_err", {30'd0, err_code}, 32'd0);
    check_val("rst_cnt", {16'd0, cycle_count}, 32'd0);
    rst_n = 1'b1;

    // good load, core requesting the port throughout (must not be granted)
    core_fetch_req = 1'b1; core_fetch_addr = 5'd2;
    send_byte(8'h03, 1'b0, 5'd0);
    send_byte(8'h01, 1'b1, 5'd0);
    send_byte(8'h05, 1'b1, 5'd1);
    send_byte(8'h02, 1'b1, 5'd2);
    send_byte(8'h06, 1'b0, 5'd0);
    @(negedge clk);
    check_val("load_ready", {29'd0, state_o}, 32'd3);
    check_val("load_err", {30'd0, err_code}, 32'd0);
    check_val("ready_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("load_sb_empty", exp_q.size(), 32'd0);

    // run to halt, core fetching addr 2
    base_run = run_cnt; base_clr = clr_cnt;
    pulse_start();
    wait_state(3'd5, 10);
    check_val("run_fetch", {28'd0, core_fetch_gnt, mem_re, core_run_en, 1'b0}, 32'he);
    check_val("run_addr", {27'd0, mem_addr}, 32'd2);
    wait_state(3'd6, 30);
    check_val("run1_clr", clr_cnt - base_clr, 32'd1);
    check_val("run1_len", run_cnt - base_run, 32'd7);
    check_val("run1_cnt", {16'd0, cycle_count}, 32'd7);
    check_val("run1_done", {30'd0, done, core_run_en}, 32'd2);

    // re-run from DONE without reload
    base_run = run_cnt;
    pulse_start();
    wait_state(3'd5, 10);
    check_val("rerun_cnt0", {16'd0, cycle_count}, 32'd0);
    wait_state(3'd6, 30);
    check_val("rerun_len", run_cnt - base_run, 32'd7);
    check_val("rerun_cnt", {16'd0, cycle_count}, 32'd7);
    core_fetch_req = 1'b0;

    // bad lengths 0 and 25
    pulse_abort();
    send_byte(8'h00, 1'b0, 5'd0);
    @(negedge clk);
    check_val("len0_state", {29'd0, state_o}, 32'd7);
    check_val("len0_err", {30'd0, err_code}, 32'd1);
    check_val("err_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_abort();
    send_byte(8'h19, 1'b0, 5'd0);
    @(negedge clk);
    check_val("len25_err", {27'd0, state_o, err_code}, {27'd0, 3'd7, 2'd1});
    pulse_abort();

    // checksum error then abort
    send_byte(8'h02, 1'b0, 5'd0);
    send_byte(8'hAA, 1'b1, 5'd0);
    send_byte(8'h55, 1'b1, 5'd1);
    send_byte(8'h00, 1'b0, 5'd0);
    @(negedge clk);
    check_val("csum_err", {27'd0, state_o, err_code}, {27'd0, 3'd7, 2'd2});
    pulse_abort();
    @(negedge clk);
    check_val("abort_idle", {26'd0, state_o, err_code, in_ready}, {26'd0, 3'd0, 2'd0, 1'b1});

    // watchdog timeout after 10 RUN cycles
    send_byte(8'h01, 1'b0, 5'd0);
    send_byte(8'h7E, 1'b1, 5'd0);
    send_byte(8'h7E, 1'b0, 5'd0);
    halt_en = 1'b0;
    base_run = run_cnt;
    pulse_start();
    wait_state(3'd7, 40);
    check_val("wdog_err", {30'd0, err_code}, 32'd3);
    check_val("wdog_len", run_cnt - base_run, 32'd10);
    check_val("wdog_cnt", {16'd0, cycle_count}, 32'd10);
    check_val("wdog_run_en", {31'd0, core_run_en}, 32'd0);
    halt_en = 1'b1;
    pulse_abort();

    // abort wins over a byte in LOAD: no write, IDLE next
    send_byte(8'h02, 1'b0, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h33; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_val("abort_load", {29'd0, state_o}, 32'd0);
    check_val("final_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_load_sched.md
Name: prog_load_sched

Overview:
- Sequencer and arbiter for the 8-bit accumulator core and its single-port 32-entry instruction memory.
- Accepts a framed program over a byte-stream valid/ready port: length byte, N payload bytes, XOR checksum byte. Writes the payload into instruction memory.
- On command, clears and runs the core, grants it exclusive fetch access, and counts cycles until the core reports halt or a watchdog expires.
- Sits between the top-level pins and the core; owns the memory port mux.

Parameters:
ADDR_W, 5, instruction memory address width
DEPTH, 24, number of usable memory bytes; legal program length is 1..DEPTH
DATA_W, 8, byte width of stream and memory
WDOG_LIMIT, 16'd4000, RUN cycles allowed before timeout error
CNT_W, 16, cycle counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  stream byte valid
in_data  in  DATA_W  stream byte
in_ready  out  1  stream byte accepted when in_valid & in_ready
start  in  1  single-cycle run request
abort  in  1  single-cycle return to IDLE
core_fetch_req  in  1  core memory read request
core_fetch_addr  in  ADDR_W  core read address
core_fetch_gnt  out  1  core read granted this cycle
core_halted  in  1  core is in its HALT state
core_clr  out  1  one-cycle synchronous clear pulse to core
core_run_en  out  1  core may advance
mem_addr  out  ADDR_W  shared memory address
mem_wdata  out  DATA_W  shared memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
state_o  out  3  current state encoding
err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout
cycle_count  out  CNT_W  RUN cycles of the last or current run
done  out  1  high in DONE

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: state IDLE, in_ready 1, all strobes 0, core_clr 0, core_run_en 0, err_code 0, cycle_count 0, done 0, internal length, index and XOR accumulator 0.
- States: IDLE=0, LOAD=1, CSUM=2, READY=3, CLR=4, RUN=5, DONE=6, ERR=7.
- IDLE: in_ready=1.
  - Accepted byte L with L==0 or L>DEPTH -> ERR, err_code=1.
  - Otherwise store L, index=0, xor=0 -> LOAD.
- LOAD: in_ready=1. Each accepted byte is written combinationally the same cycle: mem_we=1, mem_addr=index, mem_wdata=in_data. Then xor^=in_data and index++. Accepting byte number L -> CSUM.
- CSUM: in_ready=1. Accepted byte equal to xor -> READY; otherwise -> ERR, err_code=2.
- READY: in_ready=0. start -> CLR.
- CLR: core_clr=1 for exactly one cycle; cycle_count<=0 -> RUN.
- RUN:
  - core_run_en=1.
  - core_fetch_gnt=core_fetch_req, combinational, same cycle; mem_re=core_fetch_req; mem_addr=core_fetch_addr.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - core_halted=1 -> DONE. This check takes priority over the watchdog on the same cycle.
  - Otherwise, when cycle_count reaches WDOG_LIMIT-1 -> ERR, err_code=3.
- DONE: done=1, core_run_en=0, cycle_count held. start -> CLR to re-run the same program without reload.
- ERR: all strobes 0, in_ready=0. err_code held until abort.
- Arbitration: core_fetch_gnt=0 and core_run_en=0 in every non-RUN state. The loader never drives mem_we in RUN, so write and read never overlap.
- abort: from any state, next state is IDLE and err_code clears. abort wins over start and over an accepted byte in the same cycle; that byte is dropped and not written.
- start is ignored outside READY and DONE.
- in_valid is ignored when in_ready=0.
- Index arithmetic is ADDR_W bits and never wraps, because L<=DEPTH<2^ADDR_W.
- Reset mid-operation: immediate return to reset values. Memory contents are undefined to the block and are reloaded by protocol.

Decomposition:
- Package prog_load_pkg holds:
  - state enum (3 bits)
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT
  - DEPTH and WDOG_LIMIT defaults
- One natural sub-module: frame_rx, the IDLE/LOAD/CSUM byte deframer with length check and XOR accumulation. It emits write strobes plus ok/err pulses.
- The run sequencer and memory mux stay in the top.

Test Plan:
- Load 03,01,05,02 with csum 06 -> writes mem[0]=01, mem[1]=05, mem[2]=02, state READY, err_code 0.
- From READY, pulse start, model halts after 7 RUN cycles -> core_clr pulses once, core_run_en high 7 cycles, DONE, cycle_count=7.
- Length byte 00, and separately 19 (25) -> ERR, err_code=1, no mem_we.
- Payload 02,AA,55 with csum 00 -> ERR, err_code=2. Then abort -> IDLE, err_code 0, in_ready 1.
- Run with core_halted held low and WDOG_LIMIT=10 -> ERR, err_code=3 after 10 RUN cycles, core_run_en drops.
- In LOAD with in_valid=1 stall, abort the same cycle -> no write, IDLE next cycle. In DONE, start -> re-run with cycle_count cleared. core_fetch_req during LOAD -> core_fetch_gnt 0.
